tdd_frame_sched: RTL and testbench
==================================

Name: tdd_frame_sched

Overview:
- Frame-timing scheduler for the AXI2S sample-stream datapath, in the Sclk domain.
- Keeps a per-frame sample counter and produces the frame `sync` pulse plus the `ien` (RX-to-memory) and `oen` (memory-to-TX) stream enables that gate AXI2S.
- Supports TDD windows, an FDD always-on mode, and a one-shot frame-length adjustment for timing alignment.
- All configuration comes from the AXI2SREG register space; synchronisation into Sclk happens upstream.

Parameters:
- CNT_W, 24: width of the sample counter, frame length and window bounds.
- FNUM_W, 32: width of the frame number counter.

Ports:
- clk  in  1  Sclk. Single clock; the only clock in the block.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request. Level-sensitive.
- tddmode  in  1  1 = TDD windows; 0 = FDD, both enables held high while running.
- frame_len  in  CNT_W  frame length in samples.
- tstart, tend  in  CNT_W  TX window bounds, half-open [tstart, tend).
- rstart, rend  in  CNT_W  RX window bounds, half-open [rstart, rend).
- frame_adj  in  CNT_W  signed two's-complement length delta.
- adj_req  in  1  one-cycle pulse that requests an adjustment.
- adj_pending  out  1  adjustment accepted but not yet completed.
- sync  out  1  one-cycle pulse on the first sample of each frame.
- ien  out  1  RX stream enable.
- oen  out  1  TX stream enable.
- phase  out  CNT_W  registered sample index within the frame.
- frame_num  out  FNUM_W  count of frames started since run began. Wraps.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE and cnt = 0.
  - Shadow registers and the adjustment latch are cleared.
- States:
  - IDLE to RUN when enable = 1 and frame_len >= 2.
  - RUN to ADJ at a frame boundary when an adjustment is latched.
  - ADJ to RUN at the end of the adjusted frame.
  - RUN or ADJ to IDLE when enable = 0. This exit is immediate and takes priority over everything else.
  - In IDLE, cnt stays 0 and all outputs are 0 on the next cycle. frame_num is cleared on IDLE to RUN.
- Shadowing:
  - frame_len, tddmode and the four window bounds are captured into shadow registers on each frame-start cycle (cnt = 0), including the first frame.
  - Changes made mid-frame take effect at the next frame.
- Counting:
  - cnt increments every clk while in RUN or ADJ.
  - The last sample is cnt = L-1, after which cnt returns to 0.
  - L is the shadowed frame_len in RUN, and the effective length Le in ADJ.
- Output latency:
  - Outputs are registered and reflect the cnt value of the previous cycle.
  - sync = 1 in the cycle that follows cnt = 0.
  - phase equals the previous cnt.
  - frame_num increments together with sync. It reads 1 during the first sync cycle.
- Window decode, per window with bounds s and e:
  - s < e: active when s <= cnt < e.
  - s > e: wraps; active when cnt >= s or cnt < e.
  - s = e: never active.
  - Bounds >= L are compared as-is with no clamping, so a window can be truncated.
- Enable outputs:
  - TDD: ien = RX window, oen = TX window.
  - FDD: ien = oen = 1 for every running cycle.
- Adjustment:
  - adj_req is accepted only while adj_pending = 0. Accepting it latches frame_adj and sets adj_pending on the next cycle.
  - adj_req while adj_pending = 1 is ignored.
  - The first frame that starts after acceptance runs in ADJ with Le = frame_len + frame_adj, computed as signed CNT_W+1 arithmetic.
  - Le < 2 is clamped to 2. Le >= 2^CNT_W is clamped to 2^CNT_W - 1.
  - adj_pending clears in the cycle after the adjusted frame's last sample, coincident with the next sync.
  - If adj_req arrives in the same cycle as a last sample (cnt = L-1), it is accepted and applied to the frame after the one that starts next.
- Disable or reset mid-operation discards any latched adjustment and clears adj_pending.
- frame_len < 2 at IDLE exit: the block remains in IDLE. A shadowed frame_len < 2 captured while running is also treated as 2.

Decomposition:
- Package tdd_sched_pkg:
  - state enum {IDLE, RUN, ADJ}.
  - CNT_W and FNUM_W defaults.
  - Constant MIN_FRAME = 2.
- Sub-module tdd_window:
  - Combinational half-open, wrap-aware window compare of cnt against s and e.
  - Instantiated twice, once for RX and once for TX.
- Parent holds the counter, FSM, shadow registers, adjustment latch and output registers.

Test Plan:
- TDD basic: frame_len = 10, rstart = 2, rend = 5, tstart = 6, tend = 9, enable rises at S-2. Required: sync at S, S+10, S+20; ien high S+2..S+4; oen high S+6..S+8; frame_num = 1, 2, 3 at successive syncs.
- Wrap window: rstart = 8, rend = 2, frame_len = 10. Required: ien high at phases 8, 9, 0, 1 of every frame. With tstart = tend = 3, oen never rises.
- FDD: tddmode = 0, frame_len = 4. Required: ien = oen = 1 continuously from S; sync every 4 cycles. Toggling tddmode mid-frame changes the enables only from the next sync.
- Adjust: frame_len = 10, frame_adj = -3, adj_req mid-frame. Required: adj_pending = 1 the next cycle; the next frame is 7 samples; adj_pending falls at the following sync, then 10-sample frames resume. A second adj_req while pending has no effect. frame_adj = -9 is clamped to a 2-sample frame.
- Simultaneous: adj_req at cnt = 9 with frame_len = 10. Required: the frame that starts next is 10 samples and the one after it is adjusted.
- Disable/reset mid-frame: enable = 0 at phase 5. Required: all outputs 0 next cycle and adj_pending cleared. Async rst asserted mid-cycle clears outputs without waiting for a clock edge. Re-enable gives sync with frame_num = 1.

Source files
------------

// File: rtl/tdd_sched_pkg.sv
// Shared types and constants for the TDD/FDD frame-timing scheduler.
package tdd_sched_pkg;

    localparam int unsigned CNT_W_DEF  = 24;
    localparam int unsigned FNUM_W_DEF = 32;
    localparam int unsigned MIN_FRAME  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADJ  = 2'd2
    } state_t;

endpackage

// File: rtl/tdd_window.sv
// Half-open, wrap-aware window compare: [s, e) when s < e, wrapping when s > e, empty when s == e.
module tdd_window #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] s,
    input  logic [W-1:0] e,
    output logic         active
);

    always_comb begin
        active = 1'b0;
        if (s < e) begin
            active = (cnt >= s) && (cnt < e);
        end else if (s > e) begin
            active = (cnt >= s) || (cnt < e);
        end
    end

endmodule

// File: rtl/tdd_frame_sched.sv
// Frame-timing scheduler: sample counter, frame sync, RX/TX stream enables and
// one-shot frame-length adjustment, all in the Sclk domain.
module tdd_frame_sched
    import tdd_sched_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned FNUM_W = FNUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tddmode,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic [CNT_W-1:0]  tstart,
    input  logic [CNT_W-1:0]  tend,
    input  logic [CNT_W-1:0]  rstart,
    input  logic [CNT_W-1:0]  rend,
    input  logic [CNT_W-1:0]  frame_adj,
    input  logic              adj_req,
    output logic              adj_pending,
    output logic              sync,
    output logic              ien,
    output logic              oen,
    output logic [CNT_W-1:0]  phase,
    output logic [FNUM_W-1:0] frame_num
);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, len_q, ts_q, te_q, rs_q, re_q, adj_q;
    logic             tdd_q, adj_fin;

    logic             run, last;
    logic [CNT_W-1:0] len_base, len_start, ts_e, te_e, rs_e, re_e;
    logic             tdd_e, rx_act, tx_act;
    logic [CNT_W+1:0] le_wide;

    always_comb begin
        run      = (state != IDLE) && enable;
        last     = (cnt != '0) && (cnt == len_q - 1'b1);
        len_base = (frame_len < CNT_W'(MIN_FRAME)) ? CNT_W'(MIN_FRAME) : frame_len;
        // Two guard bits keep len + signed delta free of overflow before clamping.
        le_wide  = {2'b00, len_base} + {{2{adj_q[CNT_W-1]}}, adj_q};
        if (le_wide[CNT_W+1] || (le_wide[CNT_W:0] < (CNT_W+1)'(MIN_FRAME))) begin
            len_start = CNT_W'(MIN_FRAME);
        end else if (le_wide[CNT_W]) begin
            len_start = '1;
        end else begin
            len_start = le_wide[CNT_W-1:0];
        end
        if (state != ADJ) begin
            len_start = len_base;
        end
        // On the frame-start cycle the shadows are still loading, so decode from live config.
        ts_e  = (cnt == '0) ? tstart  : ts_q;
        te_e  = (cnt == '0) ? tend    : te_q;
        rs_e  = (cnt == '0) ? rstart  : rs_q;
        re_e  = (cnt == '0) ? rend    : re_q;
        tdd_e = (cnt == '0) ? tddmode : tdd_q;
    end

    tdd_window #(.W(CNT_W)) u_rx_win (
        .cnt    (cnt),
        .s      (rs_e),
        .e      (re_e),
        .active (rx_act)
    );

    tdd_window #(.W(CNT_W)) u_tx_win (
        .cnt    (cnt),
        .s      (ts_e),
        .e      (te_e),
        .active (tx_act)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (enable && (frame_len >= CNT_W'(MIN_FRAME))) state_d = RUN;
            RUN: begin
                if (!enable)                 state_d = IDLE;
                else if (last && adj_pending) state_d = ADJ;
            end
            ADJ: begin
                if (!enable)   state_d = IDLE;
                else if (last) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            len_q       <= '0;
            ts_q        <= '0;
            te_q        <= '0;
            rs_q        <= '0;
            re_q        <= '0;
            tdd_q       <= 1'b0;
            adj_q       <= '0;
            adj_fin     <= 1'b0;
            adj_pending <= 1'b0;
            sync        <= 1'b0;
            ien         <= 1'b0;
            oen         <= 1'b0;
            phase       <= '0;
            frame_num   <= '0;
        end else if (!run) begin
            cnt         <= '0;
            adj_q       <= '0;
            adj_fin     <= 1'b0;
            adj_pending <= 1'b0;
            sync        <= 1'b0;
            ien         <= 1'b0;
            oen         <= 1'b0;
            phase       <= '0;
            frame_num   <= '0;
        end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (cnt == '0) begin
                len_q <= len_start;
                ts_q  <= tstart;
                te_q  <= tend;
                rs_q  <= rstart;
                re_q  <= rend;
                tdd_q <= tddmode;
            end
            // Pending is held through the first post-adjust frame-start so it drops with that sync.
            adj_fin <= (state == ADJ) && last;
            if (adj_fin) begin
                adj_pending <= 1'b0;
            end else if (adj_req && !adj_pending) begin
                adj_pending <= 1'b1;
                adj_q       <= frame_adj;
            end
            sync      <= (cnt == '0);
            phase     <= cnt;
            frame_num <= frame_num + FNUM_W'(cnt == '0);
            ien       <= tdd_e ? rx_act : 1'b1;
            oen       <= tdd_e ? tx_act : 1'b1;
        end
    end

endmodule

// File: tb/tb_tdd_frame_sched.sv
// Directed self-checking bench for tdd_frame_sched; expected values are hand-derived per cycle.
module tb_tdd_frame_sched;

    localparam int CW = 24;
    localparam int FW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable, tddmode, adj_req;
    logic [CW-1:0] frame_len, tstart, tend, rstart, rend, frame_adj;
    logic          adj_pending, sync, ien, oen;
    logic [CW-1:0] phase;
    logic [FW-1:0] frame_num;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    tdd_frame_sched #(.CNT_W(CW), .FNUM_W(FW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tddmode     (tddmode),
        .frame_len   (frame_len),
        .tstart      (tstart),
        .tend        (tend),
        .rstart      (rstart),
        .rend        (rend),
        .frame_adj   (frame_adj),
        .adj_req     (adj_req),
        .adj_pending (adj_pending),
        .sync        (sync),
        .ien         (ien),
        .oen         (oen),
        .phase       (phase),
        .frame_num   (frame_num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle S: the first sync of a fresh run.
    task automatic restart();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic set_win(input int rs, input int re, input int ts, input int te);
        rstart = CW'(rs);
        rend   = CW'(re);
        tstart = CW'(ts);
        tend   = CW'(te);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " sync"},  32'(sync),        32'd0);
        chk({tag, " ien"},   32'(ien),         32'd0);
        chk({tag, " oen"},   32'(oen),         32'd0);
        chk({tag, " phase"}, 32'(phase),       32'd0);
        chk({tag, " fnum"},  frame_num,        32'd0);
        chk({tag, " pend"},  32'(adj_pending), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] ien_pat, oen_pat;
        int         p;

        rst = 1'b1; enable = 1'b0; tddmode = 1'b1; adj_req = 1'b0;
        frame_len = CW'(10); frame_adj = '0;
        set_win(2, 5, 6, 9);
        tick(); tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        // TDD basic
        restart();
        ien_pat = 10'b0000011100;
        oen_pat = 10'b0111000000;
        for (int k = 0; k < 30; k++) begin
            p = k % 10;
            chk($sformatf("tdd sync k=%0d", k),  32'(sync),  32'(p == 0));
            chk($sformatf("tdd phase k=%0d", k), 32'(phase), 32'(p));
            chk($sformatf("tdd ien k=%0d", k),   32'(ien),   32'(ien_pat[p]));
            chk($sformatf("tdd oen k=%0d", k),   32'(oen),   32'(oen_pat[p]));
            chk($sformatf("tdd fnum k=%0d", k),  frame_num,  32'(k / 10 + 1));
            tick();
        end

        // Wrapping RX window, empty TX window
        set_win(8, 2, 3, 3);
        restart();
        ien_pat = 10'b1100000011;
        for (int k = 0; k < 20; k++) begin
            p = k % 10;
            chk($sformatf("wrap ien k=%0d", k), 32'(ien),  32'(ien_pat[p]));
            chk($sformatf("wrap oen k=%0d", k), 32'(oen),  32'd0);
            chk($sformatf("wrap sync k=%0d", k), 32'(sync), 32'(p == 0));
            tick();
        end

        // FDD, then switch to TDD mid-frame
        tddmode = 1'b0;
        frame_len = CW'(4);
        restart();
        for (int k = 0; k < 20; k++) begin
            p = k % 4;
            chk($sformatf("fdd sync k=%0d", k),  32'(sync),  32'(p == 0));
            chk($sformatf("fdd phase k=%0d", k), 32'(phase), 32'(p));
            chk($sformatf("fdd ien k=%0d", k),   32'(ien),   (k < 16) ? 32'd1 : 32'(p < 2));
            chk($sformatf("fdd oen k=%0d", k),   32'(oen),   (k < 16) ? 32'd1 : 32'd0);
            if (k == 12) tddmode = 1'b1;
            tick();
        end

        // Adjust by -3 with an ignored second request
        frame_len = CW'(10);
        set_win(2, 5, 6, 9);
        frame_adj = CW'(-3);
        restart();
        for (int k = 0; k < 39; k++) begin
            chk($sformatf("adj sync k=%0d", k), 32'(sync),
                32'(k == 0 || k == 10 || k == 17 || k == 27 || k == 37));
            chk($sformatf("adj pend k=%0d", k), 32'(adj_pending), 32'(k >= 4 && k <= 16));
            if (k == 16) chk("adj phase k=16", 32'(phase), 32'd6);
            if (k == 20) chk("adj phase k=20", 32'(phase), 32'd3);
            adj_req   = (k == 3 || k == 5);
            frame_adj = (k == 5) ? CW'(-5) : CW'(-3);
            tick();
        end
        adj_req = 1'b0;

        // Adjust by -9 clamps to a 2-sample frame
        frame_adj = CW'(-9);
        restart();
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("clamp sync k=%0d", k), 32'(sync),
                32'(k == 0 || k == 10 || k == 12 || k == 22));
            chk($sformatf("clamp pend k=%0d", k), 32'(adj_pending), 32'(k >= 4 && k <= 11));
            adj_req = (k == 3);
            tick();
        end
        adj_req = 1'b0;

        // Request on the last sample applies one frame later
        frame_adj = CW'(-3);
        restart();
        for (int k = 0; k < 39; k++) begin
            chk($sformatf("simul sync k=%0d", k), 32'(sync),
                32'(k == 0 || k == 10 || k == 20 || k == 27 || k == 37));
            chk($sformatf("simul pend k=%0d", k), 32'(adj_pending), 32'(k >= 9 && k <= 26));
            adj_req = (k == 8);
            tick();
        end
        adj_req = 1'b0;

        // Disable at phase 5 with an adjustment pending
        restart();
        for (int k = 0; k < 6; k++) begin
            adj_req = (k == 2);
            if (k == 5) begin
                chk("dis phase5", 32'(phase), 32'd5);
                chk("dis pend5",  32'(adj_pending), 32'd1);
            end
            if (k < 5) tick();
        end
        adj_req = 1'b0;
        enable  = 1'b0;
        tick();
        chk_idle("disabled");
        enable = 1'b1;
        tick();
        chk("reen start sync", 32'(sync), 32'd0);
        tick();
        for (int k = 0; k < 21; k++) begin
            chk($sformatf("reen sync k=%0d", k), 32'(sync), 32'(k == 0 || k == 10 || k == 20));
            chk($sformatf("reen pend k=%0d", k), 32'(adj_pending), 32'd0);
            if (k == 0) chk("reen fnum", frame_num, 32'd1);
            tick();
        end

        // Asynchronous reset mid-cycle
        chk("pre-rst phase", 32'(phase), 32'd1);
        chk("pre-rst fnum",  frame_num,  32'd3);
        #3;
        rst = 1'b1;
        #1;
        chk_idle("async rst");
        #1;
        rst = 1'b0;
        tick();
        chk("post-rst start sync", 32'(sync), 32'd0);
        tick();
        chk("post-rst sync",  32'(sync),  32'd1);
        chk("post-rst fnum",  frame_num,  32'd1);
        chk("post-rst phase", 32'(phase), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
